clock_time_ctrl: RTL and testbench

//  Timekeeping controller for the digital clock. Generates single-cycle 1 kHz and 1 Hz tick enables.

---
 rtl/clock_pkg.sv | 28 ++
 rtl/clock_time_ctrl_if.sv | 23 ++
 rtl/tick_gen.sv | 46 ++++
 rtl/clock_time_ctrl.sv | 124 ++++++++++++
 tb/tb_clock_time_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared mode encodings, time-field limits and wrap helpers for the clock controller.
// Pure declarations: no latency, no backpressure.
package clock_pkg;

  localparam logic [1:0] MODE_RUN      = 2'd0;
  localparam logic [1:0] MODE_SET_HOUR = 2'd1;
  localparam logic [1:0] MODE_SET_MIN  = 2'd2;

  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] SEC_MAX  = 6'd59;

  typedef enum logic [1:0] {
    ST_RUN      = MODE_RUN,
    ST_SET_HOUR = MODE_SET_HOUR,
    ST_SET_MIN  = MODE_SET_MIN,
    ST_BAD      = 2'd3
  } mode_e;

  function automatic logic [4:0] inc_hour(input logic [4:0] v);
    return (v == HOUR_MAX) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [5:0] inc_sexa(input logic [5:0] v, input logic [5:0] max);
    return (v == max) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/clock_time_ctrl_if.sv
// Button-in / time-and-tick-out bundle between button logic, controller and display.
// Wiring only: no latency, no backpressure (pulses are fire-and-forget).
interface clock_time_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [1:0] mode;
  logic       blink;
  logic       tick_1khz;
  logic       tick_1hz;

  modport master (
    output btn_mode, btn_inc,
    input  hour, minute, second, mode, blink, tick_1khz, tick_1hz
  );

  modport slave (
    input  btn_mode, btn_inc,
    output hour, minute, second, mode, blink, tick_1khz, tick_1hz
  );
endinterface

// File: rtl/tick_gen.sv
// Two-stage prescaler: 1 kHz and 1 Hz single-cycle enables from the core clock.
// Ticks are registered (1 cycle after terminal count); clr_1hz restarts the 1 Hz stage only.
module tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk_100M,
  input  logic rst_n,
  input  logic clr_1hz,
  output logic tick_1khz,
  output logic tick_1hz
);

  localparam int             A_MAX_I = CLK_HZ / 1000 - 1;
  localparam int             A_W     = $clog2(A_MAX_I + 1);
  localparam logic [A_W-1:0] A_MAX   = A_W'(A_MAX_I);
  localparam int             B_W     = $clog2(1000);
  localparam logic [B_W-1:0] B_MAX   = B_W'(999);

  logic [A_W-1:0] a_q;
  logic [B_W-1:0] b_q;
  logic           tick_1khz_q;
  logic           tick_1hz_q;

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      tick_1khz_q <= 1'b0;
      tick_1hz_q  <= 1'b0;
    end else begin
      a_q         <= (a_q == A_MAX) ? '0 : a_q + A_W'(1);
      tick_1khz_q <= (a_q == A_MAX);
      // B holds still between kHz ticks, so its value now is what the next tick will see.
      tick_1hz_q  <= !clr_1hz && (a_q == A_MAX) && (b_q == B_MAX);
      if (clr_1hz) begin
        b_q <= '0;
      end else if (tick_1khz_q) begin
        b_q <= (b_q == B_MAX) ? '0 : b_q + B_W'(1);
      end
    end
  end

  assign tick_1khz = tick_1khz_q;
  assign tick_1hz  = tick_1hz_q;

endmodule

// File: rtl/clock_time_ctrl.sv
// Digital-clock core: HH:MM:SS counters, RUN/SET_HOUR/SET_MIN mode FSM and field blink.
// Time outputs update 1 cycle after tick_1hz; button pulses are always accepted, never stalled.
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BLINK_DIV = 500
) (
  input  logic              clk_100M,
  input  logic              rst_n,
  clock_time_ctrl_if.slave  bus
);

  localparam int                 BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

  logic tick_1khz;
  logic tick_1hz;
  logic clr_1hz;

  mode_e              mode_q,      mode_d;
  logic [4:0]         hour_q,      hour_d;
  logic [5:0]         minute_q,    minute_d;
  logic [5:0]         second_q,    second_d;
  logic               blink_q,     blink_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk_100M  (clk_100M),
    .rst_n     (rst_n),
    .clr_1hz   (clr_1hz),
    .tick_1khz (tick_1khz),
    .tick_1hz  (tick_1hz)
  );

  always_comb begin
    mode_d      = mode_q;
    hour_d      = hour_q;
    minute_d    = minute_q;
    second_d    = second_q;
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    clr_1hz     = 1'b0;

    case (mode_q)
      ST_RUN: begin
        if (tick_1hz) begin
          second_d = inc_sexa(second_q, SEC_MAX);
          if (second_q == SEC_MAX) begin
            minute_d = inc_sexa(minute_q, MIN_MAX);
            if (minute_q == MIN_MAX) begin
              hour_d = inc_hour(hour_q);
            end
          end
        end
        if (bus.btn_mode) begin
          mode_d = ST_SET_HOUR;
        end
      end
      ST_SET_HOUR: begin
        if (bus.btn_mode) begin
          mode_d = ST_SET_MIN;
        end else if (bus.btn_inc) begin
          hour_d = inc_hour(hour_q);
        end
      end
      ST_SET_MIN: begin
        // Leaving set mode restarts the second so the first tick is a whole second away.
        if (bus.btn_mode) begin
          mode_d   = ST_RUN;
          second_d = '0;
          clr_1hz  = 1'b1;
        end else if (bus.btn_inc) begin
          minute_d = inc_sexa(minute_q, MIN_MAX);
        end
      end
      default: begin
        mode_d = ST_RUN;
      end
    endcase

    if (mode_d != mode_q) begin
      blink_cnt_d = '0;
      blink_d     = (mode_d != ST_RUN);
    end else if (mode_q == ST_RUN) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (tick_1khz) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d = '0;
        blink_d     = !blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= ST_RUN;
      hour_q      <= '0;
      minute_q    <= '0;
      second_q    <= '0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      mode_q      <= mode_d;
      hour_q      <= hour_d;
      minute_q    <= minute_d;
      second_q    <= second_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign bus.hour      = hour_q;
  assign bus.minute    = minute_q;
  assign bus.second    = second_q;
  assign bus.mode      = mode_q;
  assign bus.blink     = blink_q;
  assign bus.tick_1khz = tick_1khz;
  assign bus.tick_1hz  = tick_1hz;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl at CLK_HZ=4000 (1 kHz tick every 4 clk, 1 Hz every 4000 clk).
module tb_clock_time_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  clock_time_ctrl_if bus ();

  clock_time_ctrl #(.CLK_HZ(4000), .BLINK_DIV(500)) dut (
    .clk_100M (clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, "_hour"},   int'(bus.hour),   h);
    chk({tag, "_minute"}, int'(bus.minute), m);
    chk({tag, "_second"}, int'(bus.second), s);
  endtask

  // One-cycle button pulse starting at the current negedge; returns on the following negedge +1.
  task automatic press(input logic m, input logic i);
    bus.btn_mode = m;
    bus.btn_inc  = i;
    @(negedge clk);
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_1hz(input string tag, input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.tick_1hz && cyc < limit);
    chk({tag, "_seen"}, int'(bus.tick_1hz), 1);
  endtask

  task automatic wait_khz(input string tag);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.tick_1khz && cyc < 16);
    chk({tag, "_seen"}, int'(bus.tick_1khz), 1);
  endtask

  initial begin
    int n1hz, first1hz, last1hz, nkhz, khz1, khz2, lone, c;
    int exp_h, toggles, tg1, tg2;
    logic prev_blink;

    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    chk_time("rst", 0, 0, 0);
    chk("rst_mode",  int'(bus.mode), 0);
    chk("rst_blink", int'(bus.blink), 0);
    chk("rst_khz",   int'(bus.tick_1khz), 0);
    chk("rst_1hz",   int'(bus.tick_1hz), 0);

    // 1: free run; one extra cycle lets the third second land in the registers.
    rst_n = 1'b1;
    n1hz = 0; first1hz = 0; last1hz = 0; nkhz = 0; khz1 = 0; khz2 = 0; lone = 0;
    for (int i = 1; i <= 12001; i++) begin
      @(negedge clk);
      if (bus.tick_1khz) begin
        nkhz++;
        if (khz1 == 0) khz1 = i;
        else if (khz2 == 0) khz2 = i;
      end
      if (bus.tick_1hz) begin
        n1hz++;
        if (first1hz == 0) first1hz = i;
        last1hz = i;
        if (!bus.tick_1khz) lone++;
      end
    end
    chk("t1_n1hz", n1hz, 3);
    chk("t1_first1hz", first1hz, 4000);
    chk("t1_last1hz", last1hz, 12000);
    chk("t1_khz_first", khz1, 4);
    chk("t1_khz_period", khz2 - khz1, 4);
    chk("t1_nkhz", nkhz, 3000);
    chk("t1_1hz_without_khz", lone, 0);
    chk_time("t1", 0, 0, 3);
    press(1'b0, 1'b1);
    chk_time("t1_inc_in_run", 0, 0, 3);
    chk("t1_mode_after_inc", int'(bus.mode), 0);

    // 2: set 23:59, fast-forward seconds to 58, then roll over on real ticks.
    press(1'b1, 1'b0);
    repeat (23) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    repeat (59) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    chk("t2_mode", int'(bus.mode), 0);
    chk_time("t2_set", 23, 59, 0);
    force dut.tick_1hz = 1'b1;
    repeat (58) @(negedge clk);
    release dut.tick_1hz;
    chk_time("t2_ff", 23, 59, 58);
    wait_1hz("t2_tick1", 5000, c);
    chk_time("t2_pre59", 23, 59, 58);
    @(negedge clk);
    chk_time("t2_59", 23, 59, 59);
    wait_1hz("t2_tick2", 5000, c);
    chk("t2_gap", c + 1, 4000);
    chk_time("t2_pre_roll", 23, 59, 59);
    @(negedge clk);
    chk_time("t2_roll", 0, 0, 0);

    // 3: SET_HOUR, 25 increments, time frozen, blink cadence.
    exp_h = 0;
    press(1'b1, 1'b0);
    chk("t3_mode", int'(bus.mode), 1);
    chk("t3_blink_entry", int'(bus.blink), 1);
    for (int k = 0; k < 25; k++) begin
      press(1'b0, 1'b1);
      exp_h = (exp_h + 1) % 24;
    end
    chk("t3_hour", int'(bus.hour), exp_h);
    toggles = 0; tg1 = 0; tg2 = 0; n1hz = 0;
    prev_blink = bus.blink;
    for (int i = 1; i <= 12000; i++) begin
      @(negedge clk);
      if (bus.tick_1hz) n1hz++;
      if (bus.blink != prev_blink) begin
        toggles++;
        if (tg1 == 0) tg1 = i;
        else if (tg2 == 0) tg2 = i;
      end
      prev_blink = bus.blink;
    end
    chk("t3_n1hz", n1hz, 3);
    chk("t3_toggles", toggles, 6);
    chk("t3_toggle_gap", tg2 - tg1, 2000);
    chk_time("t3_frozen", exp_h, 0, 0);

    // 4: SET_MIN wrap without carry, then exit aligned to a kHz tick.
    press(1'b1, 1'b0);
    chk("t4_mode", int'(bus.mode), 2);
    chk("t4_blink_entry", int'(bus.blink), 1);
    repeat (59) press(1'b0, 1'b1);
    chk("t4_min59", int'(bus.minute), 59);
    press(1'b0, 1'b1);
    chk_time("t4_wrap", exp_h, 0, 0);
    wait_khz("t4_align");
    bus.btn_mode = 1'b1;
    @(negedge clk);
    bus.btn_mode = 1'b0;
    chk("t4_mode_run", int'(bus.mode), 0);
    chk("t4_blink_run", int'(bus.blink), 0);
    chk("t4_sec_clr", int'(bus.second), 0);
    wait_1hz("t4_next", 5000, c);
    chk("t4_delay", c + 1, 4000);

    // 5: mode+inc together on the 1 Hz tick: advance wins, tick still counted.
    bus.btn_mode = 1'b1;
    bus.btn_inc  = 1'b1;
    @(negedge clk);
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    chk("t5_mode", int'(bus.mode), 1);
    chk_time("t5", exp_h, 0, 1);

    // 6: asynchronous reset between edges, then resume from 00:00:00.
    #3 rst_n = 1'b0;
    #1;
    chk_time("t6_async", 0, 0, 0);
    chk("t6_mode", int'(bus.mode), 0);
    chk("t6_blink", int'(bus.blink), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_1hz("t6_first", 5000, c);
    chk("t6_delay", c, 4000);
    @(negedge clk);
    chk_time("t6_resume", 0, 0, 1);
    chk("t6_mode_run", int'(bus.mode), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
